// File: rtl/video_passthru_mux.sv
// ---------------------------------------------------------------------------
// video_passthru_mux
//
// Pixel-path processor that sits between a DVI decoder and encoder. It
// delays the decoded syncs by a fixed number of pixel clocks. It also
// replaces the pixel stream with one of four sources, selected per frame:
//   0 pass         : input pixel data (blanking data included)
//   1 colour bars  : 8 vertical bars, each 2**BAR_SHIFT pixels wide
//   2 solid        : solid_rgb on active pixels
//   3 black        : all zero
// A mode request is only acted on at the start of a frame (vsync rise).
// This keeps a frame from ever mixing two modes.
//
// Ports
//   pclk           pixel clock, all state on rising edge
//   rstbtn_n       asynchronous active-low reset (deassertion synchronised)
//   in_de/hsync/vsync, in_data   decoded input stream
//   mode_req       requested mode, sampled at vsync rise
//   solid_rgb      colour for solid mode, sampled every cycle
//   out_de/hsync/vsync, out_data stream delayed by DELAY cycles
//   active_mode    mode currently applied
//   x_cnt, y_cnt   input-side pixel / line position (saturating at 4095)
//   frame_toggle   inverts once per frame, when active_mode loads
// ---------------------------------------------------------------------------
module video_passthru_mux #(
    parameter int CHANNELS  = 3,
    parameter int DW        = 8,
    parameter int DELAY     = 2,
    parameter int BAR_SHIFT = 7
) (
    input  logic                   pclk,
    input  logic                   rstbtn_n,
    input  logic                   in_de,
    input  logic                   in_hsync,
    input  logic                   in_vsync,
    input  logic [CHANNELS*DW-1:0] in_data,
    input  logic [1:0]             mode_req,
    input  logic [CHANNELS*DW-1:0] solid_rgb,
    output logic                   out_de,
    output logic                   out_hsync,
    output logic                   out_vsync,
    output logic [CHANNELS*DW-1:0] out_data,
    output logic [1:0]             active_mode,
    output logic [11:0]            x_cnt,
    output logic [11:0]            y_cnt,
    output logic                   frame_toggle
);

    localparam int          PW      = CHANNELS * DW;
    localparam int          SW      = PW + 3;      // {de, hsync, vsync, pixel}
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    // -----------------------------------------------------------------------
    // Reset synchroniser
    // -----------------------------------------------------------------------
    // NOTE: reset asserts asynchronously, so the outputs drop at once even
    // without a clock. Release goes through two flops, so every state flop
    // leaves reset on the same clock edge. That edge is the second pclk
    // rising edge after rstbtn_n goes high.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge pclk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // Input-side state: edge detectors, position counters, frame mode
    // -----------------------------------------------------------------------
    logic        vs_prev_q, vs_prev_d;
    logic        de_prev_q, de_prev_d;
    logic [11:0] x_cnt_q, x_cnt_d;
    logic [11:0] y_cnt_q, y_cnt_d;
    mode_e       active_mode_q, active_mode_d;
    logic        frame_toggle_q, frame_toggle_d;
    logic        vs_rise;
    logic        de_fall;

    assign vs_rise = in_vsync & ~vs_prev_q;
    assign de_fall = de_prev_q & ~in_de;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first. This keeps any path from inferring a latch.
    always_comb begin
        vs_prev_d      = in_vsync;
        de_prev_d      = in_de;

        // x counts active pixels. A low de returns it to zero, so it reads
        // 0 from the cycle after de falls.
        x_cnt_d        = '0;
        if (in_de) begin
            x_cnt_d = (x_cnt_q == CNT_MAX) ? x_cnt_q : x_cnt_q + 12'd1;
        end

        // Start of frame takes priority over end of line.
        y_cnt_d        = y_cnt_q;
        if (vs_rise) begin
            y_cnt_d = '0;
        end else if (de_fall && (y_cnt_q != CNT_MAX)) begin
            y_cnt_d = y_cnt_q + 12'd1;
        end

        // The mode is taken from mode_req only at the frame boundary.
        active_mode_d  = active_mode_q;
        frame_toggle_d = frame_toggle_q;
        if (vs_rise) begin
            active_mode_d  = mode_e'(mode_req);
            frame_toggle_d = ~frame_toggle_q;
        end
    end

    // -----------------------------------------------------------------------
    // Pixel source selection (evaluated on the input cycle)
    // -----------------------------------------------------------------------
    logic [2:0]    bar_idx;
    logic [2:0]    bar_v;
    logic [PW-1:0] bar_pix;
    logic [PW-1:0] pix_sel;

    assign bar_idx = x_cnt_q[BAR_SHIFT +: 3];
    assign bar_v   = 3'd7 - bar_idx;

    // Channel c lights when bit (c mod 3) of v is set. Extra channels beyond
    // three therefore repeat the R/G/B pattern.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_bar
        assign bar_pix[c*DW +: DW] = {DW{bar_v[c % 3]}};
    end

    always_comb begin
        pix_sel = '0;
        case (active_mode_q)
            MODE_PASS:  pix_sel = in_data;
            MODE_BARS:  if (in_de) pix_sel = bar_pix;
            MODE_SOLID: if (in_de) pix_sel = solid_rgb;
            default:    pix_sel = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Delay line. Syncs and the generated pixel travel together, so a mode
    // change can never shift sync timing relative to data.
    // -----------------------------------------------------------------------
    logic [SW-1:0] dly_q [DELAY];
    logic [SW-1:0] dly_d [DELAY];

    always_comb begin
        dly_d[0] = {in_de, in_hsync, in_vsync, pix_sel};
        for (int i = 1; i < DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: the delay-line stages are reset like every other flop. This
    // matters because the outputs come straight from the last stage, and
    // they must read zero for as long as reset is held.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q      <= 1'b0;
            de_prev_q      <= 1'b0;
            x_cnt_q        <= '0;
            y_cnt_q        <= '0;
            active_mode_q  <= MODE_PASS;
            frame_toggle_q <= 1'b0;
            for (int i = 0; i < DELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            vs_prev_q      <= vs_prev_d;
            de_prev_q      <= de_prev_d;
            x_cnt_q        <= x_cnt_d;
            y_cnt_q        <= y_cnt_d;
            active_mode_q  <= active_mode_d;
            frame_toggle_q <= frame_toggle_d;
            for (int i = 0; i < DELAY; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign {out_de, out_hsync, out_vsync, out_data} = dly_q[DELAY-1];
    assign active_mode  = active_mode_q;
    assign x_cnt        = x_cnt_q;
    assign y_cnt        = y_cnt_q;
    assign frame_toggle = frame_toggle_q;

endmodule

// File: tb/tb_video_passthru_mux.sv
// ---------------------------------------------------------------------------
// Directed bench for video_passthru_mux. Two instances share the control
// inputs:
//   u_dut  : defaults (3 x 8 bit, DELAY 2)
//   u_dut4 : 4 x 10 bit, DELAY 1
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at
// the same point.
// ---------------------------------------------------------------------------
module tb_video_passthru_mux;

    logic        pclk     = 1'b0;
    logic        rstbtn_n = 1'b1;
    logic        in_de, in_hsync, in_vsync;
    logic [23:0] in_data, solid_rgb;
    logic [39:0] in_data4, solid4;
    logic [1:0]  mode_req;

    logic        out_de, out_hsync, out_vsync, frame_toggle;
    logic [23:0] out_data;
    logic [1:0]  active_mode;
    logic [11:0] x_cnt, y_cnt;

    logic        out_de4, out_hsync4, out_vsync4, frame_toggle4;
    logic [39:0] out_data4;
    logic [1:0]  active_mode4;
    logic [11:0] x_cnt4, y_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                                 24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};

    always #5 pclk = ~pclk;

    video_passthru_mux u_dut (
        .pclk(pclk), .rstbtn_n(rstbtn_n),
        .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_data(in_data),
        .mode_req(mode_req), .solid_rgb(solid_rgb),
        .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_data(out_data),
        .active_mode(active_mode), .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_toggle(frame_toggle)
    );

    video_passthru_mux #(.CHANNELS(4), .DW(10), .DELAY(1), .BAR_SHIFT(7)) u_dut4 (
        .pclk(pclk), .rstbtn_n(rstbtn_n),
        .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_data(in_data4),
        .mode_req(mode_req), .solid_rgb(solid4),
        .out_de(out_de4), .out_hsync(out_hsync4), .out_vsync(out_vsync4), .out_data(out_data4),
        .active_mode(active_mode4), .x_cnt(x_cnt4), .y_cnt(y_cnt4), .frame_toggle(frame_toggle4)
    );

    // One pixel clock: apply inputs, wait for the edge, settle 1 ns.
    task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] d);
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
        in_data  = d;
        in_data4 = {16'h0, d};
        @(posedge pclk);
        #1;
    endtask

    // Produce a clean vsync rise with mode m requested, then return to blanking.
    task automatic frame_start(input logic [1:0] m);
        mode_req = m;
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 1'b1, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic test_reset;
        rstbtn_n  = 1'b0;
        mode_req  = 2'd1;
        solid_rgb = 24'hABCDEF;
        solid4    = 40'h55_5555_5555;
        repeat (3) cyc(1'b1, 1'b1, 1'b1, $urandom);
        n_tests++;
        if ({out_de, out_hsync, out_vsync, out_data, active_mode, x_cnt, y_cnt, frame_toggle} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got de=%b hs=%b vs=%b data=%h mode=%0d x=%0d y=%0d ft=%b want all 0",
                     out_de, out_hsync, out_vsync, out_data, active_mode, x_cnt, y_cnt, frame_toggle);
        end
        n_tests++;
        if ({out_de4, out_data4, x_cnt4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs4: got de=%b data=%h x=%0d want 0", out_de4, out_data4, x_cnt4);
        end
        in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_data = '0; in_data4 = '0;
        #2 rstbtn_n = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        n_tests++;
        if (active_mode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release_mode: got %0d want 0", active_mode);
        end
    endtask

    // Small random frame in pass mode: every output equals the input of the
    // previous sample point (DELAY 2), or of this one for the DELAY 1 instance.
    task automatic test_pass;
        logic [26:0] prev, cur;
        mode_req = 2'd0;
        prev     = '0;
        for (int line = 0; line < 10; line++) begin
            for (int col = 0; col < 26; col++) begin
                cur = {(line >= 2 && col < 20), (col >= 21 && col < 24), (line < 1), 24'($urandom)};
                cyc(cur[26], cur[25], cur[24], cur[23:0]);
                n_tests++;
                if ({out_de, out_hsync, out_vsync, out_data} !== prev) begin
                    n_fail++;
                    $display("FAIL pass_delay2 l%0d c%0d: got %h want %h", line, col,
                             {out_de, out_hsync, out_vsync, out_data}, prev);
                end
                n_tests++;
                if ({out_de4, out_hsync4, out_vsync4, out_data4} !== {cur[26:24], 16'h0, cur[23:0]}) begin
                    n_fail++;
                    $display("FAIL pass_delay1 l%0d c%0d: got %h want %h", line, col,
                             {out_de4, out_hsync4, out_vsync4, out_data4}, {cur[26:24], 16'h0, cur[23:0]});
                end
                prev = cur;
            end
        end
        n_tests++;
        if (y_cnt !== 12'd8 || x_cnt !== 12'd0) begin
            n_fail++;
            $display("FAIL pass_counters: got x=%0d y=%0d want x=0 y=8", x_cnt, y_cnt);
        end
    endtask

    task automatic test_bars;
        frame_start(2'd1);
        n_tests++;
        if (active_mode !== 2'd1) begin
            n_fail++;
            $display("FAIL bars_mode: got %0d want 1", active_mode);
        end
        for (int p = 0; p <= 1024; p++) begin
            if (p == 500) mode_req = 2'd3;   // mid-frame request must be ignored
            cyc(p < 1024, 1'b0, 1'b0, $urandom);
            if (p >= 1) begin
                n_tests++;
                if (out_data !== bar_tab[(p-1) >> 7] || out_de !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bars_pixel %0d: got de=%b %h want de=1 %h", p - 1, out_de, out_data,
                             bar_tab[(p-1) >> 7]);
                end
            end
        end
        cyc(1'b0, 1'b1, 1'b0, $urandom);
        n_tests++;
        if (out_data !== 24'h0 || out_de !== 1'b0 || active_mode !== 2'd1) begin
            n_fail++;
            $display("FAIL bars_blanking: got de=%b data=%h mode=%0d want de=0 data=0 mode=1",
                     out_de, out_data, active_mode);
        end
    endtask

    // Long line on the 4-channel, DELAY 1 instance: saturation and channel 3.
    task automatic test_sat;
        logic [39:0] exp4;
        logic        chk;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        for (int p = 0; p < 5000; p++) begin
            cyc(1'b1, 1'b0, 1'b0, $urandom);
            if (p == 0) begin
                n_tests++;
                if (out_de4 !== 1'b1 || out_de !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_de_latency: got de4=%b de=%b want 1 0", out_de4, out_de);
                end
            end
            chk = 1'b1;
            case (p)
                0:       exp4 = 40'hFF_FFFF_FFFF;
                128:     exp4 = 40'h00_3FFF_FC00;
                384:     exp4 = 40'h00_3FF0_0000;
                640:     exp4 = 40'h00_000F_FC00;
                768:     exp4 = 40'hFF_C000_03FF;
                1024:    exp4 = 40'hFF_FFFF_FFFF;
                4095:    exp4 = 40'h0;
                4200:    exp4 = 40'h0;
                default: begin exp4 = 40'h0; chk = 1'b0; end
            endcase
            if (chk) begin
                n_tests++;
                if (out_data4 !== exp4) begin
                    n_fail++;
                    $display("FAIL sat_bar4 pixel %0d: got %h want %h", p, out_data4, exp4);
                end
            end
        end
        n_tests++;
        if (x_cnt4 !== 12'd4095 || x_cnt !== 12'd4095) begin
            n_fail++;
            $display("FAIL sat_x: got x4=%0d x=%0d want 4095", x_cnt4, x_cnt);
        end
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        n_tests++;
        if (out_de4 !== 1'b0 || out_de !== 1'b1 || x_cnt4 !== 12'd0) begin
            n_fail++;
            $display("FAIL sat_line_end: got de4=%b de=%b x4=%0d want 0 1 0", out_de4, out_de, x_cnt4);
        end
    endtask

    task automatic test_mode_switch;
        logic [23:0] prev_d, d;
        logic        ft0;
        frame_start(2'd0);
        solid_rgb = 24'h123456;
        solid4    = 40'h12_3456_789A;
        prev_d    = 24'h0;
        for (int p = 0; p < 10; p++) begin
            if (p == 5) mode_req = 2'd2;
            d = $urandom;
            cyc(1'b1, 1'b0, 1'b0, d);
            n_tests++;
            if (out_data !== prev_d) begin
                n_fail++;
                $display("FAIL switch_pass pixel %0d: got %h want %h", p, out_data, prev_d);
            end
            prev_d = d;
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        ft0 = frame_toggle;
        in_vsync = 1'b1;
        n_tests++;
        if (active_mode !== 2'd0) begin
            n_fail++;
            $display("FAIL switch_before_edge: got %0d want 0", active_mode);
        end
        cyc(1'b0, 1'b0, 1'b1, 24'h0);
        n_tests++;
        if (active_mode !== 2'd2 || frame_toggle !== ~ft0) begin
            n_fail++;
            $display("FAIL switch_load: got mode=%0d ft=%b want 2 %b", active_mode, frame_toggle, ~ft0);
        end
        cyc(1'b0, 1'b0, 1'b1, 24'h0);
        n_tests++;
        if (frame_toggle !== ~ft0) begin
            n_fail++;
            $display("FAIL switch_toggle_once: got %b want %b", frame_toggle, ~ft0);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        for (int p = 0; p <= 8; p++) begin
            cyc(p < 8, 1'b0, 1'b0, $urandom);
            if (p >= 1) begin
                n_tests++;
                if (out_data !== 24'h123456) begin
                    n_fail++;
                    $display("FAIL switch_solid pixel %0d: got %h want 123456", p - 1, out_data);
                end
            end
            if (p < 8) begin
                n_tests++;
                if (out_data4 !== 40'h12_3456_789A) begin
                    n_fail++;
                    $display("FAIL switch_solid4 pixel %0d: got %h want 123456789a", p, out_data4);
                end
            end
        end
        cyc(1'b0, 1'b0, 1'b0, $urandom);
        n_tests++;
        if (out_data !== 24'h0 || out_data4 !== 40'h0) begin
            n_fail++;
            $display("FAIL switch_blank: got %h %h want 0 0", out_data, out_data4);
        end
    endtask

    task automatic test_mode_toggle;
        frame_start(2'd3);
        cyc(1'b1, 1'b0, 1'b0, $urandom);
        cyc(1'b0, 1'b0, 1'b0, $urandom);
        n_tests++;
        if (active_mode !== 2'd3 || out_de !== 1'b1 || out_data !== 24'h0) begin
            n_fail++;
            $display("FAIL black_pixel: got mode=%0d de=%b data=%h want 3 1 0", active_mode, out_de, out_data);
        end
        mode_req = 2'd1; repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        mode_req = 2'd3; repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        mode_req = 2'd2; repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        n_tests++;
        if (active_mode !== 2'd3) begin
            n_fail++;
            $display("FAIL toggle_ignored: got %0d want 3", active_mode);
        end
        cyc(1'b0, 1'b0, 1'b1, 24'h0);
        mode_req = 2'd1;
        cyc(1'b0, 1'b0, 1'b1, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        n_tests++;
        if (active_mode !== 2'd2) begin
            n_fail++;
            $display("FAIL toggle_load: got %0d want 2", active_mode);
        end
        solid_rgb = 24'h00A5C3;
        cyc(1'b1, 1'b0, 1'b0, $urandom);
        cyc(1'b0, 1'b0, 1'b0, $urandom);
        n_tests++;
        if (out_data !== 24'h00A5C3) begin
            n_fail++;
            $display("FAIL toggle_solid: got %h want 00a5c3", out_data);
        end
    endtask

    task automatic test_y_cnt;
        frame_start(2'd0);
        n_tests++;
        if (y_cnt !== 12'd0) begin
            n_fail++;
            $display("FAIL y_clear: got %0d want 0", y_cnt);
        end
        for (int l = 0; l < 3; l++) begin
            repeat (4) cyc(1'b1, 1'b0, 1'b0, $urandom);
            if (l == 0) begin
                n_tests++;
                if (x_cnt !== 12'd4) begin
                    n_fail++;
                    $display("FAIL x_count: got %0d want 4", x_cnt);
                end
            end
            repeat (2) cyc(1'b0, 1'b1, 1'b0, $urandom);
        end
        n_tests++;
        if (y_cnt !== 12'd3 || x_cnt !== 12'd0) begin
            n_fail++;
            $display("FAIL y_lines: got y=%0d x=%0d want 3 0", y_cnt, x_cnt);
        end
        repeat (2) cyc(1'b1, 1'b0, 1'b0, $urandom);
        cyc(1'b0, 1'b0, 1'b1, 24'h0);        // de fall and vsync rise together
        n_tests++;
        if (y_cnt !== 12'd0) begin
            n_fail++;
            $display("FAIL y_coincident: got %0d want 0", y_cnt);
        end
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic test_reset_mid;
        logic [23:0] prev_d, d;
        frame_start(2'd1);
        repeat (2) begin
            repeat (4) cyc(1'b1, 1'b0, 1'b0, $urandom);
            repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        end
        repeat (20) cyc(1'b1, 1'b0, 1'b0, $urandom);
        n_tests++;
        if (out_data !== 24'hFFFFFF || out_de !== 1'b1 || active_mode !== 2'd1 ||
            x_cnt !== 12'd20 || y_cnt !== 12'd2) begin
            n_fail++;
            $display("FAIL rstmid_before: got data=%h de=%b mode=%0d x=%0d y=%0d want ffffff 1 1 20 2",
                     out_data, out_de, active_mode, x_cnt, y_cnt);
        end
        #2 rstbtn_n = 1'b0;
        #1;
        n_tests++;
        if ({out_de, out_data, active_mode, x_cnt, y_cnt} !== '0 || out_data4 !== 40'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got de=%b data=%h mode=%0d x=%0d y=%0d d4=%h want 0",
                     out_de, out_data, active_mode, x_cnt, y_cnt, out_data4);
        end
        repeat (2) begin
            @(posedge pclk);
            #1;
        end
        n_tests++;
        if (x_cnt !== 12'd0 || out_de !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_held: got x=%0d de=%b want 0 0", x_cnt, out_de);
        end
        #2 rstbtn_n = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        n_tests++;
        if (active_mode !== 2'd0 || x_cnt !== 12'd0 || y_cnt !== 12'd0) begin
            n_fail++;
            $display("FAIL rstmid_release: got mode=%0d x=%0d y=%0d want 0 0 0", active_mode, x_cnt, y_cnt);
        end
        prev_d = 24'h0;
        for (int p = 0; p < 5; p++) begin
            d = $urandom;
            cyc(1'b1, 1'b0, 1'b0, d);
            n_tests++;
            if (out_data !== prev_d || x_cnt !== 12'(p + 1)) begin
                n_fail++;
                $display("FAIL rstmid_pass pixel %0d: got data=%h x=%0d want %h %0d", p, out_data, x_cnt,
                         prev_d, p + 1);
            end
            prev_d = d;
        end
        frame_start(2'd1);
        n_tests++;
        if (active_mode !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_reapply: got %0d want 1", active_mode);
        end
    endtask

    initial begin
        in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        in_data = '0; in_data4 = '0; mode_req = 2'd0;
        solid_rgb = '0; solid4 = '0;
        test_reset();
        test_pass();
        test_bars();
        test_sat();
        test_mode_switch();
        test_mode_toggle();
        test_y_cnt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
